// File: rtl/fpga_trading_core.sv
// fpga_trading_core: top-of-book spread trigger gated by a mid-price momentum predictor
module fpga_trading_core #(
  parameter int unsigned SPREAD_THRESHOLD = 5,
  parameter int unsigned PRICE_W          = 32,
  parameter int unsigned SIZE_W           = 32,
  parameter bit          AI_BYPASS        = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               market_data_valid,
  input  logic [PRICE_W-1:0] market_data_price,
  input  logic [SIZE_W-1:0]  market_data_size,
  input  logic               market_data_side,
  output logic               send_order
);
  logic [PRICE_W-1:0] best_bid_price, best_ask_price, bid_d, ask_d;
  logic               bid_ok_q, ask_ok_q, bid_ok_d, ask_ok_d;
  logic [PRICE_W:0]   prev_mid_q, prev_mid_d, mid, spread;
  logic               ai_prediction, ai_d, cond, send_order_q;
  logic               bid_upd, ask_upd, mid_upd;
  // Book next state, predictor next state and the trade condition on the current book
  always_comb begin
    bid_upd    = market_data_valid & ~market_data_side;
    ask_upd    = market_data_valid & market_data_side;
    bid_d      = bid_upd ? market_data_price : best_bid_price;
    ask_d      = ask_upd ? market_data_price : best_ask_price;
    bid_ok_d   = bid_upd ? (market_data_size != '0) : bid_ok_q;
    ask_ok_d   = ask_upd ? (market_data_size != '0) : ask_ok_q;
    mid        = ({1'b0, bid_d} + {1'b0, ask_d}) >> 1;
    mid_upd    = market_data_valid & bid_ok_d & ask_ok_d;
    prev_mid_d = mid_upd ? mid : prev_mid_q;
    ai_d       = AI_BYPASS ? 1'b1 : (mid_upd ? (mid >= prev_mid_q) : ai_prediction);
    spread     = {1'b0, best_ask_price} - {1'b0, best_bid_price};
    cond       = bid_ok_q & ask_ok_q & (best_ask_price > best_bid_price)
               & (spread > (PRICE_W+1)'(SPREAD_THRESHOLD)) & ai_prediction;
  end
  // State register; prediction resets high when the model is bypassed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_bid_price <= '0;
      best_ask_price <= '0;
      bid_ok_q       <= 1'b0;
      ask_ok_q       <= 1'b0;
      prev_mid_q     <= '0;
      ai_prediction  <= AI_BYPASS;
      send_order_q   <= 1'b0;
    end else begin
      best_bid_price <= bid_d;
      best_ask_price <= ask_d;
      bid_ok_q       <= bid_ok_d;
      ask_ok_q       <= ask_ok_d;
      prev_mid_q     <= prev_mid_d;
      ai_prediction  <= ai_d;
      send_order_q   <= cond;
    end
  end
  assign send_order = send_order_q;
endmodule

// File: tb/tb_fpga_trading_core.sv
// tb_fpga_trading_core: directed vectors with a queued scoreboard for bypass and momentum variants
module tb_fpga_trading_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        side = 1'b0;
  logic [31:0] price = '0;
  logic [31:0] size = '0;
  logic        so_byp, so_mdl;
  int          checks = 0;
  int          errors = 0;

  typedef struct { int kind; logic s; logic [31:0] p; logic [31:0] z; logic e1; logic e0; } vec_t;
  typedef struct { int idx; logic e1; logic e0; } exp_t;
  vec_t vecs[$];
  exp_t sb[$];

  fpga_trading_core u_byp (.clk(clk), .rst_n(rst_n), .market_data_valid(valid),
    .market_data_price(price), .market_data_size(size), .market_data_side(side),
    .send_order(so_byp));
  fpga_trading_core #(.AI_BYPASS(1'b0)) u_mdl (.clk(clk), .rst_n(rst_n), .market_data_valid(valid),
    .market_data_price(price), .market_data_size(size), .market_data_side(side),
    .send_order(so_mdl));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input int kind, input logic s, input int p, input int z, input logic e1, input logic e0);
    vecs.push_back('{kind, s, 32'(p), 32'(z), e1, e0});
  endtask

  task automatic reset_checks(input int idx);
    chk("rst_send_byp", idx, 64'(so_byp), 0);
    chk("rst_send_mdl", idx, 64'(so_mdl), 0);
    chk("rst_bid", idx, 64'(u_byp.best_bid_price), 0);
    chk("rst_ask", idx, 64'(u_mdl.best_ask_price), 0);
    chk("rst_ai_byp", idx, 64'(u_byp.ai_prediction), 1);
    chk("rst_ai_mdl", idx, 64'(u_mdl.ai_prediction), 0);
  endtask

  // Monitor: send_order is presented every cycle, so compare just after each rising edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("send_byp", e.idx, 64'(so_byp), 64'(e.e1));
      chk("send_mdl", e.idx, 64'(so_mdl), 64'(e.e0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // kind 0 = idle (valid low, garbage on bus), 1 = update, 2 = reset
    add(0,0,0,0,0,0); add(0,0,0,0,0,0);
    add(1,0,1000,10,0,0); add(1,1,1002,10,0,0); add(1,1,1010,10,0,0);
    add(0,0,0,0,1,1); add(0,0,0,0,1,1);
    add(1,0,1009,10,1,1); add(0,0,0,0,0,0); add(0,0,0,0,0,0);
    add(1,0,1000,10,0,0); add(1,1,1005,10,1,0); add(0,0,0,0,0,0); add(0,0,0,0,0,0);
    add(1,1,995,10,0,0); add(0,0,0,0,0,0);
    add(1,1,1010,0,0,0); add(0,0,0,0,0,0); add(0,0,0,0,0,0);
    add(2,0,0,0,0,0);
    add(1,1,1010,10,0,0); add(0,0,0,0,0,0); add(0,0,0,0,0,0);
    add(2,0,0,0,0,0);
    add(1,0,1000,10,0,0); add(1,1,1010,10,0,0); add(0,0,0,0,1,1);
    add(1,0,990,10,1,1); add(1,1,996,10,1,0); add(0,0,0,0,1,0); add(0,0,0,0,1,0);
    add(2,0,0,0,0,0);
    repeat (2) @(negedge clk);
    reset_checks(-1);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].kind == 2) begin
        valid = 1'b0;
        if (i == vecs.size() - 1) chk("pre_rst_send_byp", i, 64'(so_byp), 1);
        rst_n = 1'b0;
        #1;
        reset_checks(i);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end else begin
        valid = (vecs[i].kind == 1);
        side  = vecs[i].kind == 1 ? vecs[i].s : 1'b0;
        price = vecs[i].kind == 1 ? vecs[i].p : 32'd7;
        size  = vecs[i].kind == 1 ? vecs[i].z : 32'd0;
        sb.push_back('{i, vecs[i].e1, vecs[i].e0});
      end
    end
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", 0, 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
